ad9866_cmd_arb: RTL and testbench
=================================

AD9866_CMD_ARB -- requirements
Module: ad9866_cmd_arb

Interface
REQ-001 SHALL provide parameter NREQ, default 3, meaning number of register-write requesters (fixed at 3 for this release).
REQ-002 SHALL provide parameter DEPTH, default 4, meaning command FIFO entries (power of 2).
REQ-003 SHALL provide clk_ad9866  input  1  system clock; all logic on rising edge.
REQ-004 SHALL provide rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL provide req  input  3  per-requester command valid.
REQ-006 SHALL provide cmd0, cmd1, cmd2  input  13 each  command {addr[12:8], data[7:0]} for requester 0/1/2.
REQ-007 SHALL provide gnt  output  3  one-hot accept; the command is captured on the edge where gnt is high.
REQ-008 SHALL provide spi_start  output  1  single-cycle start pulse to the SPI shifter.
REQ-009 SHALL provide spi_data  output  16  word {3'b000, addr, data}.
REQ-010 SHALL provide spi_busy  input  1  high while the shifter transfers (inverted SPI enable).
REQ-011 SHALL provide fifo_level  output  3  number of queued entries, 0..4.

Function
REQ-012 SHALL drive gnt combinationally from registered state and req: at most one bit high; all zero when fifo_level==4 (unless REQ-027 applies).
REQ-013 SHALL arbitrate round-robin: search starts at rr_ptr; after a grant to requester k, rr_ptr becomes (k+1) mod 3.
REQ-014 SHALL push the granted command at the FIFO tail on that edge; the requester holds req and cmd until it sees gnt.
REQ-015 SHALL use issue FSM states IDLE, WAIT_BUSY and WAIT_DONE.
REQ-016 In IDLE, with fifo_level>0 and spi_busy==0, SHALL pulse spi_start for one cycle, load spi_data from the head entry on the same edge, and go to WAIT_BUSY.
REQ-017 In WAIT_BUSY, on spi_busy==1, SHALL pop the head and go to WAIT_DONE.
REQ-018 In WAIT_BUSY, if spi_busy stays 0 for 8 cycles, SHALL return to IDLE without popping, so the head is retried.
REQ-019 In WAIT_DONE, on spi_busy==0, SHALL return to IDLE; the next spi_start comes no earlier than the following cycle.
REQ-020 SHALL hold spi_data stable between start pulses.
REQ-021 On a simultaneous push and pop, SHALL leave fifo_level unchanged; the full test uses the level at cycle start, so there is no same-cycle bypass at full.
REQ-022 SHALL wrap read and write pointers modulo DEPTH; fifo_level never exceeds 4 or underflows.
REQ-023 SHALL preserve FIFO order: commands issue in grant order.
REQ-024 With spi_busy held high by a foreign master, SHALL remain in IDLE with no spi_start.

Reset
REQ-025 While rst_n==0, SHALL force gnt=0, spi_start=0, spi_data=16'h0000, fifo_level=0, FSM=IDLE and rr_ptr=0.
REQ-026 Reset asserted mid-transfer SHALL discard all queued entries, including the in-flight head, and issue no further spi_start until after reset releases.

Configuration
REQ-027 With macro AD9866_CMD_COALESCE_EN defined:
- An incoming command whose addr matches a queued, non-locked entry overwrites that entry's data in place.
- gnt is still asserted and fifo_level is unchanged; this is allowed even when the FIFO is full.
- The head is locked from spi_start until it is popped.
- At most one unlocked entry exists per address.
REQ-028 Without AD9866_CMD_COALESCE_EN, every grant appends a new entry, duplicates included, and no grant is given while fifo_level==4.

Verification
REQ-029 Reset -> spi_start=0, fifo_level=0, spi_data=16'h0000, gnt=0 for every cycle rst_n is low.
REQ-030 req=3'b111 with cmd0=13'h0A04, cmd1=13'h0941, cmd2=13'h0C43 held -> gnt order 001, 010, 100; spi_data sequence 16'h0A04, 16'h0941, 16'h0C43.
REQ-031 Fill to 4 with spi_busy=1 -> fifo_level=4 and gnt=0; release spi_busy -> one start, pop, then one further grant.
REQ-032 spi_busy never rises after a start -> spi_start re-pulses 9 cycles later with the same spi_data; fifo_level is unchanged.
REQ-033 With AD9866_CMD_COALESCE_EN: queue 13'h0A01 behind a locked head, then send 13'h0A07 -> fifo_level unchanged; the issued word is 16'h0A07.
REQ-034 rst_n low during WAIT_DONE with 3 queued -> fifo_level=0 next cycle; no spi_start after release until a new grant.

Source files
------------

// File: rtl/ad9866_cmd_arb_if.sv
// Bus bundle for the AD9866 register-write command arbiter.
// The slave modport is the arbiter; the master modport is the requester/SPI side.
interface ad9866_cmd_arb_if;
   logic [2:0]  req;
   logic [12:0] cmd0;
   logic [12:0] cmd1;
   logic [12:0] cmd2;
   logic [2:0]  gnt;
   logic        spi_start;
   logic [15:0] spi_data;
   logic        spi_busy;
   logic [2:0]  fifo_level;

   modport slave (
      input  req, cmd0, cmd1, cmd2, spi_busy,
      output gnt, spi_start, spi_data, fifo_level
   );

   modport master (
      output req, cmd0, cmd1, cmd2, spi_busy,
      input  gnt, spi_start, spi_data, fifo_level
   );
endinterface

// File: rtl/ad9866_cmd_arb.sv
// AD9866 register-write command arbiter.
// Three requesters are arbitrated round-robin into a small command FIFO; an
// issue FSM hands the head entry to the SPI shifter and pops it only once the
// shifter acknowledges by raising spi_busy (otherwise the head is retried).
// Optional build macro AD9866_CMD_COALESCE_EN: a command whose address matches
// a queued, unlocked entry overwrites that entry's data instead of appending.
module ad9866_cmd_arb #(
   parameter int NREQ  = 3,
   parameter int DEPTH = 4
) (
   input logic             clk_ad9866,
   input logic             rst_n,
   ad9866_cmd_arb_if.slave bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH + 1);
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
   // Last WAIT_BUSY cycle index: eight cycles without spi_busy means the start was missed
   localparam logic [2:0] TMO_LAST = 3'd7;

   typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

   logic [12:0]     r_mem [DEPTH];
   logic [AW-1:0]   r_rd;
   logic [AW-1:0]   r_wr;
   logic [LW-1:0]   r_level;
   logic [1:0]      r_rr;
   state_t          r_state;
   logic [2:0]      r_tmo;
   logic            r_start;
   logic [15:0]     r_data;

   logic [12:0]     w_cmd [NREQ];
   logic            w_full;
   logic            w_issue;
   logic            w_pop;
   logic            w_push;
   logic [NREQ-1:0] w_elig;
   logic [NREQ-1:0] w_gnt;
   logic [1:0]      w_gidx;
   logic            w_any;
   logic [2:0]      w_sum;
   logic [1:0]      w_j;
   logic [12:0]     w_cmd_sel;

   assign w_cmd[0]  = bus.cmd0;
   assign w_cmd[1]  = bus.cmd1;
   assign w_cmd[2]  = bus.cmd2;
   assign w_full    = (r_level == FULL_LVL);
   assign w_issue   = (r_state == IDLE) && (r_level != '0) && !bus.spi_busy;
   assign w_pop     = (r_state == WAIT_BUSY) && bus.spi_busy && (r_level != '0);
   assign w_cmd_sel = w_cmd[w_gidx];

`ifdef AD9866_CMD_COALESCE_EN
   logic            r_lock;
   logic            w_head_locked;
   logic [NREQ-1:0] w_hit;
   logic [AW-1:0]   w_hit_idx [NREQ];
   logic [AW-1:0]   w_off;
   logic            w_coal;
   logic [AW-1:0]   w_coal_idx;

   // The head being issued this cycle is treated as locked so its data cannot change under the SPI load
   assign w_head_locked = r_lock || w_issue;
   assign w_coal        = w_any && w_hit[w_gidx];
   assign w_coal_idx    = w_hit_idx[w_gidx];
   assign w_push        = w_any && !w_coal;

   // Find, per requester, a queued unlocked entry with the same register address
   always_comb begin
      w_off = '0;
      for (int k = 0; k < NREQ; k++) begin
         w_hit[k]     = 1'b0;
         w_hit_idx[k] = '0;
         for (int e = 0; e < DEPTH; e++) begin
            w_off = AW'(e) - r_rd;
            if ((LW'(w_off) < r_level) &&
                !(w_head_locked && (AW'(e) == r_rd)) &&
                (r_mem[e][12:8] == w_cmd[k][12:8])) begin
               w_hit[k]     = 1'b1;
               w_hit_idx[k] = AW'(e);
            end
         end
      end
   end

   // A requester may be served when there is room or when it will merge into an existing entry
   always_comb begin
      for (int k = 0; k < NREQ; k++)
         w_elig[k] = rst_n && bus.req[k] && (!w_full || w_hit[k]);
   end
`else
   assign w_push = w_any;

   // A requester may be served whenever the FIFO has room
   always_comb begin
      for (int k = 0; k < NREQ; k++)
         w_elig[k] = rst_n && bus.req[k] && !w_full;
   end
`endif

   // Round-robin pick: first eligible requester at or after r_rr
   always_comb begin
      w_gnt  = '0;
      w_gidx = '0;
      w_any  = 1'b0;
      w_sum  = '0;
      w_j    = '0;
      for (int i = 0; i < NREQ; i++) begin
         w_sum = {1'b0, r_rr} + 3'(i);
         if (w_sum >= 3'(NREQ))
            w_sum = w_sum - 3'(NREQ);
         w_j = w_sum[1:0];
         if (!w_any && w_elig[w_j]) begin
            w_gnt[w_j] = 1'b1;
            w_gidx     = w_j;
            w_any      = 1'b1;
         end
      end
   end

   // Command storage: append at the tail, or merge data into a matching entry
   always_ff @(posedge clk_ad9866) begin
      if (w_push)
         r_mem[r_wr] <= w_cmd_sel;
`ifdef AD9866_CMD_COALESCE_EN
      if (w_coal)
         r_mem[w_coal_idx][7:0] <= w_cmd_sel[7:0];
`endif
   end

   // FIFO pointers and occupancy; push and pop together leave the level unchanged
   always_ff @(posedge clk_ad9866) begin
      if (!rst_n) begin
         r_rd    <= '0;
         r_wr    <= '0;
         r_level <= '0;
      end else begin
         if (w_push)
            r_wr <= r_wr + AW'(1);
         if (w_pop)
            r_rd <= r_rd + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // Round-robin pointer moves to the requester after the one just granted
   always_ff @(posedge clk_ad9866) begin
      if (!rst_n)
         r_rr <= '0;
      else if (w_any)
         r_rr <= (w_gidx == 2'(NREQ - 1)) ? 2'd0 : w_gidx + 2'd1;
   end

   // Issue FSM: start the head, pop on shifter acknowledge, retry on timeout
   always_ff @(posedge clk_ad9866) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_start <= 1'b0;
         r_data  <= 16'h0000;
         r_tmo   <= '0;
`ifdef AD9866_CMD_COALESCE_EN
         r_lock  <= 1'b0;
`endif
      end else begin
         r_start <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_issue) begin
                  r_start <= 1'b1;
                  r_data  <= {3'b000, r_mem[r_rd]};
                  r_tmo   <= '0;
                  r_state <= WAIT_BUSY;
`ifdef AD9866_CMD_COALESCE_EN
                  r_lock  <= 1'b1;
`endif
               end
            end
            WAIT_BUSY: begin
               if (bus.spi_busy) begin
                  r_state <= WAIT_DONE;
`ifdef AD9866_CMD_COALESCE_EN
                  r_lock  <= 1'b0;
`endif
               end else if (r_tmo == TMO_LAST) begin
                  r_state <= IDLE;
               end else begin
                  r_tmo <= r_tmo + 3'd1;
               end
            end
            WAIT_DONE: begin
               if (!bus.spi_busy)
                  r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.gnt        = w_gnt;
   assign bus.spi_start  = r_start;
   assign bus.spi_data   = r_data;
   assign bus.fifo_level = 3'(r_level);

endmodule

// File: tb/tb_ad9866_cmd_arb.sv
// Directed self-checking bench for ad9866_cmd_arb.
// Build with +define+AD9866_CMD_COALESCE_EN to include the coalescing case.
module tb_ad9866_cmd_arb;

   logic clk_ad9866 = 1'b0;
   logic rst_n;

   always #5 clk_ad9866 = ~clk_ad9866;

   ad9866_cmd_arb_if bus ();

   ad9866_cmd_arb #(.NREQ(3), .DEPTH(4)) dut (
      .clk_ad9866 (clk_ad9866),
      .rst_n      (rst_n),
      .bus        (bus)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   logic        auto_en = 1'b0;
   logic        busy_manual = 1'b0;
   logic        busy_auto = 1'b0;
   int          busy_cnt = 0;
   logic [15:0] q_words [$];
   int          base;
   int          gap;

   assign bus.spi_busy = auto_en ? busy_auto : busy_manual;

   // Simple shifter model: busy for three cycles after each start pulse
   always @(negedge clk_ad9866) begin
      if (!auto_en)
         busy_cnt = 0;
      else if (bus.spi_start)
         busy_cnt = 3;
      else if (busy_cnt > 0)
         busy_cnt = busy_cnt - 1;
      busy_auto = (busy_cnt > 0);
   end

   // Record every issued SPI word
   always @(negedge clk_ad9866) begin
      if (rst_n === 1'b1 && bus.spi_start === 1'b1)
         q_words.push_back(bus.spi_data);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] word_at(input int i);
      if (i < q_words.size())
         return 32'(q_words[i]);
      return 32'hDEAD_BEEF;
   endfunction

   // Raise req[k] with command c and hold it until the grant edge has passed
   task automatic send(input logic [1:0] k, input logic [12:0] c);
      bit ok;
      ok = 1'b0;
      case (k)
         2'd0:    bus.cmd0 = c;
         2'd1:    bus.cmd1 = c;
         default: bus.cmd2 = c;
      endcase
      bus.req[k] = 1'b1;
      for (int n = 0; n < 40 && !ok; n++) begin
         #1;
         if (bus.gnt[k] === 1'b1)
            ok = 1'b1;
         @(posedge clk_ad9866); #1;
      end
      bus.req[k] = 1'b0;
      chk($sformatf("send%0d_gnt", k), 32'(ok), 1);
   endtask

   task automatic wait_drain(input string tag);
      int n;
      n = 0;
      while (n < 300 && !(bus.fifo_level == 3'd0 && bus.spi_busy == 1'b0 && bus.spi_start == 1'b0)) begin
         @(posedge clk_ad9866); #1;
         n++;
      end
      repeat (3) begin
         @(posedge clk_ad9866); #1;
      end
      chk(tag, 32'(n < 300), 1);
   endtask

   initial begin
      rst_n    = 1'b0;
      bus.cmd0 = 13'h0A04;
      bus.cmd1 = 13'h0941;
      bus.cmd2 = 13'h0C43;
      bus.req  = 3'b111;

      // Reset holds every output low even with all requests pending
      repeat (3) begin
         @(posedge clk_ad9866); #1;
         chk("rst_start", 32'(bus.spi_start), 0);
         chk("rst_level", 32'(bus.fifo_level), 0);
         chk("rst_data",  32'(bus.spi_data), 'h0000);
         chk("rst_gnt",   32'(bus.gnt), 'b000);
      end

      // Round-robin order and issue order
      rst_n   = 1'b1;
      auto_en = 1'b1;
      base    = q_words.size();
      #1 chk("rr_gnt0", 32'(bus.gnt), 'b001);
      @(posedge clk_ad9866); #1;
      bus.req = 3'b110;
      #1 chk("rr_gnt1", 32'(bus.gnt), 'b010);
      @(posedge clk_ad9866); #1;
      bus.req = 3'b100;
      #1 chk("rr_gnt2", 32'(bus.gnt), 'b100);
      @(posedge clk_ad9866); #1;
      bus.req = 3'b000;
      wait_drain("rr_drain");
      chk("rr_count", 32'(q_words.size() - base), 3);
      chk("rr_word0", word_at(base),     'h0A04);
      chk("rr_word1", word_at(base + 1), 'h0941);
      chk("rr_word2", word_at(base + 2), 'h0C43);

      // Fill to full behind a foreign busy master, then release
      auto_en     = 1'b0;
      busy_manual = 1'b1;
      base        = q_words.size();
      send(2'd0, 13'h0101);
      send(2'd0, 13'h0202);
      send(2'd0, 13'h0303);
      send(2'd0, 13'h0404);
      chk("full_level", 32'(bus.fifo_level), 4);
      bus.cmd1   = 13'h0505;
      bus.req[1] = 1'b1;
      #1 chk("full_gnt", 32'(bus.gnt), 'b000);
      repeat (2) begin
         @(posedge clk_ad9866); #1;
         chk("full_gnt_hold", 32'(bus.gnt), 'b000);
         chk("foreign_nostart", 32'(bus.spi_start), 0);
      end
      auto_en = 1'b1;
      @(posedge clk_ad9866); #1;
      chk("rel_start", 32'(bus.spi_start), 1);
      chk("rel_data",  32'(bus.spi_data), 'h0101);
      chk("rel_level", 32'(bus.fifo_level), 4);
      chk("rel_gnt0",  32'(bus.gnt), 'b000);
      @(posedge clk_ad9866); #1;
      chk("pop_start", 32'(bus.spi_start), 0);
      chk("pop_level", 32'(bus.fifo_level), 3);
      chk("pop_gnt",   32'(bus.gnt), 'b010);
      @(posedge clk_ad9866); #1;
      bus.req[1] = 1'b0;
      chk("refill_level", 32'(bus.fifo_level), 4);
      wait_drain("full_drain");
      chk("full_count", 32'(q_words.size() - base), 5);
      chk("full_word0", word_at(base),     'h0101);
      chk("full_word1", word_at(base + 1), 'h0202);
      chk("full_word2", word_at(base + 2), 'h0303);
      chk("full_word3", word_at(base + 3), 'h0404);
      chk("full_word4", word_at(base + 4), 'h0505);

      // Shifter never acknowledges: start repeats after the timeout
      auto_en     = 1'b0;
      busy_manual = 1'b0;
      send(2'd2, 13'h0B55);
      @(posedge clk_ad9866); #1;
      chk("tmo_start", 32'(bus.spi_start), 1);
      chk("tmo_data",  32'(bus.spi_data), 'h0B55);
      gap = 0;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk_ad9866); #1;
         if (bus.spi_start === 1'b1) begin
            gap = n;
            break;
         end
      end
      chk("tmo_gap",   32'(gap), 9);
      chk("tmo_data2", 32'(bus.spi_data), 'h0B55);
      chk("tmo_level", 32'(bus.fifo_level), 1);
      auto_en = 1'b1;
      wait_drain("tmo_drain");

      // Reset during WAIT_DONE with three entries still queued
      auto_en     = 1'b0;
      busy_manual = 1'b1;
      send(2'd0, 13'h0111);
      send(2'd0, 13'h0222);
      send(2'd0, 13'h0333);
      send(2'd0, 13'h0444);
      chk("mid_level4", 32'(bus.fifo_level), 4);
      busy_manual = 1'b0;
      @(posedge clk_ad9866); #1;
      chk("mid_start", 32'(bus.spi_start), 1);
      chk("mid_data",  32'(bus.spi_data), 'h0111);
      busy_manual = 1'b1;
      @(posedge clk_ad9866); #1;
      chk("mid_level3", 32'(bus.fifo_level), 3);
      rst_n   = 1'b0;
      bus.req = 3'b111;
      @(posedge clk_ad9866); #1;
      chk("mid_rst_level", 32'(bus.fifo_level), 0);
      chk("mid_rst_start", 32'(bus.spi_start), 0);
      chk("mid_rst_data",  32'(bus.spi_data), 'h0000);
      chk("mid_rst_gnt",   32'(bus.gnt), 'b000);
      rst_n       = 1'b1;
      bus.req     = 3'b000;
      busy_manual = 1'b0;
      base        = q_words.size();
      repeat (12) begin
         @(posedge clk_ad9866); #1;
      end
      chk("post_rst_nostart", 32'(q_words.size() - base), 0);
      chk("post_rst_level",   32'(bus.fifo_level), 0);
      auto_en = 1'b1;
      send(2'd1, 13'h0C33);
      wait_drain("post_rst_drain");
      chk("post_rst_count", 32'(q_words.size() - base), 1);
      chk("post_rst_word",  word_at(base), 'h0C33);

`ifdef AD9866_CMD_COALESCE_EN
      // Same-address command merges into the unlocked entry, never the locked head
      auto_en     = 1'b0;
      busy_manual = 1'b0;
      base        = q_words.size();
      send(2'd0, 13'h0A55);
      @(posedge clk_ad9866); #1;
      chk("coal_head_start", 32'(bus.spi_start), 1);
      send(2'd1, 13'h0A01);
      chk("coal_level_a", 32'(bus.fifo_level), 2);
      send(2'd2, 13'h0A07);
      chk("coal_level_b", 32'(bus.fifo_level), 2);
      busy_manual = 1'b1;
      @(posedge clk_ad9866); #1;
      chk("coal_pop_level", 32'(bus.fifo_level), 1);
      busy_manual = 1'b0;
      auto_en     = 1'b1;
      wait_drain("coal_drain");
      chk("coal_count", 32'(q_words.size() - base), 2);
      chk("coal_word0", word_at(base),     'h0A55);
      chk("coal_word1", word_at(base + 1), 'h0A07);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
